// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: datapath width, instruction size, PC alignment
// and the {instr, pc} bundle passed from fetch to decode.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, downstream redirect and
// the valid/ready handoff to decode. master = fetch stage, slave = its environment.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] iaddr;
  logic            imem_en;
  logic [XLEN-1:0] idata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            fd_valid;
  logic            fd_ready;
  logic [XLEN-1:0] fd_instr;
  logic [XLEN-1:0] fd_pc;

  modport master (
    output iaddr, imem_en, fd_valid, fd_instr, fd_pc,
    input  idata, redirect, redirect_pc, fd_ready
  );

  modport slave (
    input  iaddr, imem_en, fd_valid, fd_instr, fd_pc,
    output idata, redirect, redirect_pc, fd_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO; head visible combinationally, 1-cycle push-to-head latency.
// Caller guarantees no push when full and no pop when empty; flush beats push.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic [WIDTH-1:0]        head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues to sync-read imem, 2-cycle fetch-to-decode latency.
// Issues only while queued + in-flight words fit; a redirect squashes queue and in-flight word.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            fd_valid;
  logic            deq;
  logic            issue;
  logic            push;
  fetch_pkt_t      push_pkt;
  fetch_pkt_t      head;

  assign fd_valid  = (count != '0) && !bus.redirect;
  assign deq       = fd_valid && bus.fd_ready;
  // Crediting this cycle's dequeue lets a depth-2 queue sustain one fetch per cycle.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};
  assign issue     = !reset && !bus.redirect && (occupancy < DEPTH_LIM);
  assign push      = inflight_q && !bus.redirect;
  assign push_pkt  = '{instr: bus.idata, pc: req_pc_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (bus.redirect) begin
        pc_q <= bus.redirect_pc & PC_ALIGN_MASK;
      end else if (issue) begin
        pc_q     <= pc_q + XLEN'(INSTR_BYTES);
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_queue #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_pkt),
    .pop       (deq),
    .count     (count),
    .head      (head)
  );

  assign bus.iaddr    = pc_q;
  assign bus.imem_en  = issue;
  assign bus.fd_valid = fd_valid;
  assign bus.fd_instr = head.instr;
  assign bus.fd_pc    = head.pc;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 32-bit pipelined RISC CPU. It owns the PC and drives the synchronous-read instruction memory. It buffers returned words in a small flushable queue and hands {instruction, PC} to the decode stage over a valid/ready handshake. Taken branches and jumps resolved downstream (branch_success with target) redirect it, squashing all wrong-path work.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- QDEPTH, 2: instruction-queue entries. Power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- iaddr  out  32  instruction memory address, equal to current pc_q
- imem_en  out  1  fetch request issued this cycle
- idata  in  32  memory read data; valid the cycle after the request
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- fd_valid  out  1  queue head holds a valid instruction for decode
- fd_ready  in  1  decode accepts the head this cycle
- fd_instr  out  32  head instruction
- fd_pc  out  32  PC of head instruction

## Operation
- State: pc_q (next request address), inflight_q (request issued last cycle), req_pc_q (its address), queue count plus read/write pointers.
- deq = fd_valid & fd_ready.
- issue = !reset & !redirect & (count_q + inflight_q − deq < QDEPTH). With deq credited, QDEPTH=2 sustains 1 instruction/cycle.
- imem_en = issue and iaddr = pc_q. On issue: pc_q ← pc_q + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0), req_pc_q ← pc_q. inflight_q ← issue every cycle.
- Response: if inflight_q & !redirect, push {idata, req_pc_q}. Push and pop in the same cycle leave count unchanged. Overflow is impossible by construction; the bench asserts it.
- fd_valid = (count_q ≠ 0) & !redirect. fd_instr/fd_pc are the head entry.
- Redirect cycle:
  - pc_q ← {redirect_pc[31:2], 2'b00}.
  - Queue count and pointers ← 0.
  - inflight_q ← 0. The response arriving this cycle is discarded.
  - No handshake completes; deq is 0 even if fd_ready = 1.
  - A redirect during a later redirect simply re-targets.
- No FSM beyond this datapath state. The three modes RUN (issuing), HOLD (credit exhausted, pc_q frozen) and SQUASH (redirect cycle) all follow from the equations above.

## Timing
- Reset asserted (asynchronous, immediate):
  - pc_q = RESET_PC, so iaddr = RESET_PC.
  - imem_en = 0, inflight_q = 0, count = 0, fd_valid = 0.
  - Queue storage cleared, so fd_instr = 0 and fd_pc = 0.
- First cycle after deassertion (C0): imem_en = 1, iaddr = RESET_PC.
- C1: word pushed. C2: fd_valid = 1, fd_pc = RESET_PC.
- Fetch-to-decode latency is 2 cycles.
- Redirect sampled in cycle N:
  - N+1: iaddr = target, imem_en = 1.
  - N+3: fd_valid = 1 with fd_pc = target.
  - Cycles N to N+2 present no instruction.
- Back-pressure: with fd_ready low, the queue fills to QDEPTH, imem_en drops, and iaddr holds. Head outputs stay stable while fd_valid & !fd_ready.
- Reset mid-operation discards queue and in-flight data; fetch restarts from RESET_PC per the sequence above.

## Structure
- Shared package cpu_pkg: XLEN = 32, INSTR_BYTES = 4, PC_ALIGN_MASK = 32'hFFFF_FFFC. The decode stage reuses the {instr, pc} bundle typedef.
- Sub-module fetch_queue: synchronous FIFO parameterised by width and depth. It has push, pop, synchronous flush (priority over push), count, head output and async reset.
- fetch_stage holds the PC/credit logic and instantiates fetch_queue with width 64.

## Test plan
- Reset: reset high 3 cycles → imem_en = 0, iaddr = 0, fd_valid = 0. After release, C0 iaddr = 0; C2 fd_valid = 1, fd_pc = 0, fd_instr = mem[0].
- Streaming: model returns idata = addr ^ 32'hA5A5_0000, fd_ready = 1 → fd_pc 0, 4, 8, 12… one per cycle, no bubbles, fd_instr matches the model.
- Back-pressure: fd_ready = 0 for 6 cycles → count = 2, imem_en low, iaddr frozen. On release, fd_pc continues 0x0, 0x4, 0x8 with no drop or duplicate.
- Redirect: pulse redirect with redirect_pc = 32'h103 while the queue is full, inflight_q = 1 and fd_ready = 1 → no handshake that cycle, no stale PC ever appears, iaddr = 0x100 one cycle later, fd_pc = 0x100 at N+3.
- Wrap: redirect_pc = 32'hFFFF_FFFC → fd_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Async reset mid-stream, asserted between edges → outputs reach reset values immediately; fetch restarts at RESET_PC.
